// File: rtl/uart_tx_param.sv
// Generic FIFO with occupancy count; read data is the current head entry.
// Latency: a write is visible at the head on the edge after it is accepted.
// Backpressure: wr_rdy = !full; simultaneous read and write leave count unchanged.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_vld,
    input  logic [WIDTH-1:0]       wr_dat,
    output logic                   wr_rdy,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign wr_rdy = (count != FULL_CNT);
    assign push   = wr_vld && wr_rdy;
    assign pop    = rd_en && (count != '0);
    assign rd_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_dat;
    end
endmodule

// UART transmitter with byte FIFO, run-time divisor, parity mode and stop-bit count.
// Latency: start bit begins on the edge after a byte lands in an empty FIFO; frames chain with no gap.
// Backpressure: s_ready = FIFO not full (registered count); a pop frees a slot only for the next edge.
module uart_tx_param #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_valid,
    input  logic [7:0]                  s_data,
    output logic                        s_ready,
    input  logic [15:0]                 baud_div,
    input  logic [1:0]                  parity_mode,
    input  logic                        stop_bits,
    output logic                        tx,
    output logic                        busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);

    logic [2:0]           state;
    logic [15:0]          div_q;
    logic [15:0]          bit_cnt;
    logic [2:0]           bit_idx;
    logic                 par_en;
    logic                 par_bit;
    logic                 stop2;
    logic                 stop_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] head;
    logic                 bit_end;
    logic                 pop;
    logic                 unused_hi;

    // Upper payload bits are dropped in narrow builds.
    assign unused_hi = ^s_data;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (s_valid),
        .wr_dat (s_data[DATA_BITS-1:0]),
        .wr_rdy (s_ready),
        .rd_en  (pop),
        .rd_dat (head),
        .count  (fifo_count)
    );

    assign bit_end = (bit_cnt == div_q);
    assign busy    = (state != ST_IDLE);
    // Pop either from idle or on the very edge that closes the last stop bit.
    assign pop     = (fifo_count != '0) &&
                     ((state == ST_IDLE) ||
                      ((state == ST_STOP) && bit_end && (stop_idx == stop2)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            tx_done  <= 1'b0;
            div_q    <= '0;
            bit_cnt  <= '0;
            bit_idx  <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            stop2    <= 1'b0;
            stop_idx <= 1'b0;
            shreg    <= '0;
        end else begin
            tx_done <= 1'b0;
            if (state != ST_IDLE) bit_cnt <= bit_end ? 16'd0 : bit_cnt + 16'd1;

            case (state)
                ST_IDLE: ;
                ST_START: if (bit_end) begin
                    state   <= ST_DATA;
                    bit_idx <= '0;
                    tx      <= shreg[0];
                end
                ST_DATA: if (bit_end) begin
                    if (bit_idx == LAST_BIT) begin
                        stop_idx <= 1'b0;
                        state    <= par_en ? ST_PARITY : ST_STOP;
                        tx       <= par_en ? par_bit : 1'b1;
                    end else begin
                        bit_idx <= bit_idx + 3'd1;
                        shreg   <= shreg >> 1;
                        tx      <= shreg[1];
                    end
                end
                ST_PARITY: if (bit_end) begin
                    state <= ST_STOP;
                    tx    <= 1'b1;
                end
                ST_STOP: if (bit_end) begin
                    if (stop_idx != stop2) begin
                        stop_idx <= 1'b1;
                    end else begin
                        tx_done <= 1'b1;
                        state   <= ST_IDLE;
                        tx      <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase

            // Frame load overrides the stop-to-idle transition for back-to-back frames.
            if (pop) begin
                shreg   <= head;
                div_q   <= baud_div;
                par_en  <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
                par_bit <= (parity_mode == 2'd1) ? ~^head : ^head;
                stop2   <= stop_bits;
                bit_cnt <= '0;
                tx      <= 1'b0;
                state   <= ST_START;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: an 8-bit build plus a 7-bit build sharing clock, reset and config.
module tb_uart_tx_param;
    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid, s_valid7;
    logic [7:0]  s_data, s_data7;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;
    logic        stop_bits;
    logic        s_ready, tx, busy, tx_done;
    logic [4:0]  fifo_count;
    logic        s_ready7, tx7, busy7, tx_done7;
    logic [4:0]  fifo_count7;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_cnt7 = 0;
    int bb_stall, bb_max, bb_ready_bad, bb_timeout;
    logic cap_tx   [1024];
    logic cap_busy [1024];
    logic cap_done [1024];

    always #5 clk = ~clk;

    uart_tx_param #(.DATA_BITS(8), .FIFO_DEPTH(16)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .baud_div(baud_div), .parity_mode(parity_mode), .stop_bits(stop_bits),
        .tx(tx), .busy(busy), .tx_done(tx_done), .fifo_count(fifo_count)
    );

    uart_tx_param #(.DATA_BITS(7), .FIFO_DEPTH(16)) dut7 (
        .clk(clk), .rst(rst), .s_valid(s_valid7), .s_data(s_data7), .s_ready(s_ready7),
        .baud_div(baud_div), .parity_mode(parity_mode), .stop_bits(stop_bits),
        .tx(tx7), .busy(busy7), .tx_done(tx_done7), .fifo_count(fifo_count7)
    );

    always @(negedge clk) begin
        if (tx_done)  done_cnt  <= done_cnt + 1;
        if (tx_done7) done_cnt7 <= done_cnt7 + 1;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Records one sample per clock, starting at the current cycle.
    task automatic capture(input int n, input bit sel7);
        for (int i = 0; i < n; i++) begin
            cap_tx[i]   = sel7 ? tx7 : tx;
            cap_busy[i] = sel7 ? busy7 : busy;
            cap_done[i] = sel7 ? tx_done7 : tx_done;
            tick(1);
        end
    endtask

    function automatic logic [7:0] byte_of(input int i);
        return 8'((i * 37 + 5) & 255);
    endfunction

    // Line bit k of an 8N1 frame carrying d.
    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (tx_done !== 1'b0) begin errors++; $display("FAIL reset_tx_done: got %b expected 0", tx_done); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b expected 1", s_ready); end
        checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
        checks++; if (tx7 !== 1'b1 || fifo_count7 !== 5'd0) begin errors++; $display("FAIL reset_dut7: tx=%b count=%0d expected 1/0", tx7, fifo_count7); end
    endtask

    task automatic test_8n1();
        logic [9:0] e = 10'b1101001010;
        logic bad, got;
        int d0;
        baud_div = 16'd3; parity_mode = 2'd0; stop_bits = 1'b0;
        s_valid = 1'b1; s_data = 8'hA5;
        tick(1);
        s_valid = 1'b0;
        checks++; if (fifo_count !== 5'd1 || tx !== 1'b1) begin errors++; $display("FAIL a5_accept: count=%0d tx=%b expected 1/1", fifo_count, tx); end
        tick(1);
        checks++; if (tx !== 1'b0 || busy !== 1'b1 || fifo_count !== 5'd0) begin errors++; $display("FAIL a5_pop: tx=%b busy=%b count=%0d expected 0/1/0", tx, busy, fifo_count); end
        d0 = done_cnt;
        capture(40, 1'b0);
        for (int k = 0; k < 10; k++) begin
            bad = 1'b0; got = e[k];
            for (int j = 0; j < 4; j++)
                if (cap_tx[k*4+j] !== e[k] || cap_busy[k*4+j] !== 1'b1 || cap_done[k*4+j] !== 1'b0) begin
                    bad = 1'b1; got = cap_tx[k*4+j];
                end
            checks++; if (bad) begin errors++; $display("FAIL a5_bit%0d: tx=%b expected tx=%b busy=1 done=0", k, got, e[k]); end
        end
        checks++; if (tx_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL a5_end: done=%b busy=%b expected 1/0", tx_done, busy); end
        tick(1);
        checks++; if (tx_done !== 1'b0 || done_cnt - d0 !== 1) begin errors++; $display("FAIL a5_done_pulse: done=%b pulses=%0d expected 0/1", tx_done, done_cnt - d0); end
    endtask

    task automatic test_parity();
        logic [11:0] e;
        logic bad, got;
        baud_div = 16'd0; stop_bits = 1'b1;
        for (int m = 0; m < 2; m++) begin
            parity_mode = (m == 0) ? 2'd2 : 2'd1;
            e = (m == 0) ? 12'b111000001110 : 12'b110000001110;
            s_valid = 1'b1; s_data = 8'h07;
            tick(1);
            s_valid = 1'b0;
            tick(1);
            capture(12, 1'b0);
            bad = 1'b0; got = 1'b0;
            for (int k = 0; k < 12; k++)
                if (cap_tx[k] !== e[k] || cap_busy[k] !== 1'b1) begin bad = 1'b1; got = cap_tx[k]; end
            checks++; if (bad) begin errors++; $display("FAIL parity_frame_mode%0d: a bit read %b, expected line %b (LSB first)", parity_mode, got, e); end
            checks++; if (cap_tx[9] !== e[9]) begin errors++; $display("FAIL parity_bit_mode%0d: got %b expected %b", parity_mode, cap_tx[9], e[9]); end
            checks++; if (tx_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL parity_len_mode%0d: done=%b busy=%b expected 1/0", parity_mode, tx_done, busy); end
        end
        stop_bits = 1'b0;
    endtask

    task automatic test_data7();
        logic [9:0] e = 10'b1011111110;
        logic bad, got;
        baud_div = 16'd0; parity_mode = 2'd1; stop_bits = 1'b0;
        s_valid7 = 1'b1; s_data7 = 8'hFF;
        tick(1);
        s_valid7 = 1'b0;
        checks++; if (fifo_count7 !== 5'd1) begin errors++; $display("FAIL d7_accept: count=%0d expected 1", fifo_count7); end
        tick(1);
        capture(10, 1'b1);
        bad = 1'b0; got = 1'b0;
        for (int k = 0; k < 10; k++)
            if (cap_tx[k] !== e[k] || cap_busy[k] !== 1'b1) begin bad = 1'b1; got = cap_tx[k]; end
        checks++; if (bad) begin errors++; $display("FAIL d7_frame: a bit read %b, expected line %b (LSB first)", got, e); end
        checks++; if (tx_done7 !== 1'b1 || busy7 !== 1'b0) begin errors++; $display("FAIL d7_len: done=%b busy=%b expected 1/0", tx_done7, busy7); end
        parity_mode = 2'd0;
    endtask

    task automatic push_stream(input int n);
        int waited;
        bit acc;
        for (int i = 0; i < n; i++) begin
            s_valid = 1'b1; s_data = byte_of(i);
            acc = 1'b0; waited = 0;
            while (!acc && waited < 200) begin
                acc = s_ready;
                if (int'(fifo_count) > bb_max) bb_max = int'(fifo_count);
                if (fifo_count == 5'd16 && s_ready !== 1'b0) bb_ready_bad++;
                if (!s_ready) bb_stall++;
                tick(1);
                waited++;
            end
            if (!acc) bb_timeout++;
        end
        s_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic bad, got, ed;
        int d0, idx;
        baud_div = 16'd3; parity_mode = 2'd0; stop_bits = 1'b0;
        bb_stall = 0; bb_max = 0; bb_ready_bad = 0; bb_timeout = 0;
        d0 = done_cnt;
        fork
            push_stream(18);
            begin
                tick(2);
                capture(720, 1'b0);
            end
        join
        for (int f = 0; f < 18; f++) begin
            for (int k = 0; k < 10; k++) begin
                bad = 1'b0; got = frame_bit(byte_of(f), k);
                for (int j = 0; j < 4; j++) begin
                    idx = (f * 10 + k) * 4 + j;
                    ed = (idx != 0 && idx % 40 == 0);
                    if (cap_tx[idx] !== frame_bit(byte_of(f), k) || cap_busy[idx] !== 1'b1 || cap_done[idx] !== ed) begin
                        bad = 1'b1; got = cap_tx[idx];
                    end
                end
                checks++; if (bad) begin errors++; $display("FAIL b2b_f%0d_bit%0d: tx=%b expected tx=%b busy=1", f, k, got, frame_bit(byte_of(f), k)); end
            end
        end
        checks++; if (bb_timeout != 0) begin errors++; $display("FAIL b2b_push_timeout: %0d bytes never accepted, expected 0", bb_timeout); end
        checks++; if (bb_max != 16) begin errors++; $display("FAIL b2b_max_count: got %0d expected 16", bb_max); end
        checks++; if (bb_ready_bad != 0) begin errors++; $display("FAIL b2b_ready_when_full: %0d cycles ready high at 16, expected 0", bb_ready_bad); end
        checks++; if (bb_stall == 0) begin errors++; $display("FAIL b2b_backpressure: stall cycles %0d expected >0", bb_stall); end
        checks++; if (tx_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL b2b_end: done=%b busy=%b expected 1/0", tx_done, busy); end
        tick(1);
        checks++; if (done_cnt - d0 !== 18) begin errors++; $display("FAIL b2b_done_pulses: got %0d expected 18", done_cnt - d0); end
    endtask

    task automatic test_midframe();
        logic [9:0]  ea = 10'b1001111000;
        logic [10:0] eb = 11'b11110000010;
        logic bad, got;
        baud_div = 16'd3; parity_mode = 2'd0; stop_bits = 1'b0;
        s_valid = 1'b1; s_data = 8'h3C;
        tick(1);
        s_data = 8'hC1;
        tick(1);
        s_valid = 1'b0;
        baud_div = 16'd7; parity_mode = 2'd2;
        capture(40, 1'b0);
        bad = 1'b0; got = 1'b0;
        for (int i = 0; i < 40; i++)
            if (cap_tx[i] !== ea[i/4] || cap_busy[i] !== 1'b1 || cap_done[i] !== 1'b0) begin bad = 1'b1; got = cap_tx[i]; end
        checks++; if (bad) begin errors++; $display("FAIL mid_frame_a: a bit read %b, expected line %b at 4 clk/bit", got, ea); end
        checks++; if (tx_done !== 1'b1 || busy !== 1'b1 || tx !== 1'b0) begin errors++; $display("FAIL mid_chain: done=%b busy=%b tx=%b expected 1/1/0", tx_done, busy, tx); end
        capture(88, 1'b0);
        bad = 1'b0; got = 1'b0;
        for (int i = 0; i < 88; i++)
            if (cap_tx[i] !== eb[i/8] || cap_busy[i] !== 1'b1) begin bad = 1'b1; got = cap_tx[i]; end
        checks++; if (bad) begin errors++; $display("FAIL mid_frame_b: a bit read %b, expected line %b at 8 clk/bit", got, eb); end
        checks++; if (tx_done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL mid_end: done=%b busy=%b expected 1/0", tx_done, busy); end
        baud_div = 16'd3; parity_mode = 2'd0;
        tick(1);
    endtask

    task automatic test_reset_mid();
        logic bad;
        int d0;
        baud_div = 16'd3; parity_mode = 2'd0; stop_bits = 1'b0;
        s_valid = 1'b1; s_data = 8'h55;
        tick(4);
        s_valid = 1'b0;
        checks++; if (fifo_count !== 5'd3) begin errors++; $display("FAIL rmid_queued: count=%0d expected 3", fifo_count); end
        tick(6);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: got %b expected 1", busy); end
        d0 = done_cnt;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        checks++; if (tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 5'd0 || s_ready !== 1'b1) begin
            errors++; $display("FAIL rmid_state: tx=%b busy=%b count=%0d ready=%b expected 1/0/0/1", tx, busy, fifo_count, s_ready);
        end
        bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (tx !== 1'b1 || busy !== 1'b0) bad = 1'b1;
            tick(1);
        end
        checks++; if (bad) begin errors++; $display("FAIL rmid_quiet: line left idle or busy rose, expected tx=1 busy=0"); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL rmid_no_done: pulses=%0d expected 0", done_cnt - d0); end
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_valid7 = 1'b0; s_data7 = 8'h00;
        baud_div = 16'd3; parity_mode = 2'd0; stop_bits = 1'b0;
        test_reset();
        test_8n1();
        test_parity();
        test_data7();
        test_back_to_back();
        test_midframe();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
